// File: rtl/bus_pair_aligner.sv
// bus_pair_aligner: pairs words from two independent buses through per-channel FIFOs,
// with a skew watchdog that flushes a channel that leads the other for too long.
module bpa_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk) if (wr) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      rp  <= wp;
      cnt <= '0;
    end else begin
      wp  <= wp + AW'(wr);
      rp  <= rp + AW'(pop);
      cnt <= cnt + CW'(wr) - CW'(pop);
    end
  assign dout = mem[rp];
endmodule

module bus_pair_aligner #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              pair_valid,
  output logic [DATA_W-1:0] pair_a,
  output logic [DATA_W-1:0] pair_b,
  input  logic              pair_ready,
  input  logic              clr_err,
  output logic              a_ovf,
  output logic              b_ovf,
  output logic              skew_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  typedef enum logic {ALIGNED, SKEW} state_t;
  state_t state;
  logic [15:0] skew_cnt;
  logic [CW-1:0] a_cnt, b_cnt, a_nxt, b_nxt;
  logic [DATA_W-1:0] a_head, b_head;
  logic a_ne, b_ne, a_full, b_full, pop, flush, fl_a, fl_b, wr_a, wr_b, drop_a, drop_b, nxt_skew;
  assign a_ne       = a_cnt != '0;
  assign b_ne       = b_cnt != '0;
  assign a_full     = a_cnt == CW'(DEPTH);
  assign b_full     = b_cnt == CW'(DEPTH);
  assign pair_valid = a_ne & b_ne;
  assign pair_a     = pair_valid ? a_head : '0;
  assign pair_b     = pair_valid ? b_head : '0;
  assign pop        = pair_valid & pair_ready;
  assign flush      = (state == SKEW) && ({1'b0, skew_cnt} + 17'd1 == 17'(TIMEOUT));
  assign fl_a       = flush & a_ne;
  assign fl_b       = flush & b_ne;
  // a full FIFO still takes a word when the head leaves in the same cycle
  assign wr_a       = a_valid & (~a_full | pop) & ~fl_a;
  assign wr_b       = b_valid & (~b_full | pop) & ~fl_b;
  assign drop_a     = a_valid & a_full & ~pop & ~fl_a;
  assign drop_b     = b_valid & b_full & ~pop & ~fl_b;
  assign a_nxt      = fl_a ? '0 : a_cnt + CW'(wr_a) - CW'(pop);
  assign b_nxt      = fl_b ? '0 : b_cnt + CW'(wr_b) - CW'(pop);
  assign nxt_skew   = (a_nxt != '0) ^ (b_nxt != '0);
  bpa_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_a (
    .clk(clk), .rst(rst), .wr(wr_a), .din(a_data), .pop(pop), .flush(fl_a), .dout(a_head), .cnt(a_cnt)
  );
  bpa_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_b (
    .clk(clk), .rst(rst), .wr(wr_b), .din(b_data), .pop(pop), .flush(fl_b), .dout(b_head), .cnt(b_cnt)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= ALIGNED;
      skew_cnt <= '0;
      skew_err <= 1'b0;
      a_ovf    <= 1'b0;
      b_ovf    <= 1'b0;
    end else begin
      a_ovf <= drop_a | (a_ovf & ~clr_err);
      b_ovf <= drop_b | (b_ovf & ~clr_err);
      if (flush) begin
        state    <= ALIGNED;
        skew_cnt <= '0;
        skew_err <= 1'b1;
      end else begin
        state    <= nxt_skew ? SKEW : ALIGNED;
        skew_cnt <= (nxt_skew && state == SKEW) ? skew_cnt + 16'd1 : '0;
        skew_err <= 1'b0;
      end
    end
endmodule

// File: tb/tb_bus_pair_aligner.sv
// tb_bus_pair_aligner: directed and random stimulus against a queue-based reference model.
module tb_bus_pair_aligner;
  localparam int W = 16, D = 4, TO = 8;
  logic clk = 0, rst = 0, a_valid = 0, b_valid = 0, pair_ready = 0, clr_err = 0;
  logic [W-1:0] a_data = '0, b_data = '0, pair_a, pair_b;
  logic pair_valid, a_ovf, b_ovf, skew_err;
  int total = 0, bad = 0;
  logic [W-1:0] qa[$], qb[$];
  bit m_aovf, m_bovf, m_err, in_skew;
  int age;

  always #5 clk = ~clk;

  bus_pair_aligner #(.DATA_W(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .a_valid(a_valid), .a_data(a_data), .b_valid(b_valid), .b_data(b_data),
    .pair_valid(pair_valid), .pair_a(pair_a), .pair_b(pair_b), .pair_ready(pair_ready),
    .clr_err(clr_err), .a_ovf(a_ovf), .b_ovf(b_ovf), .skew_err(skew_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string where);
    bit pv;
    pv = qa.size() > 0 && qb.size() > 0;
    check({where, ":pair_valid"}, 32'(pair_valid), 32'(pv));
    check({where, ":pair_a"}, 32'(pair_a), pv ? 32'(qa[0]) : 32'd0);
    check({where, ":pair_b"}, 32'(pair_b), pv ? 32'(qb[0]) : 32'd0);
    check({where, ":a_ovf"}, 32'(a_ovf), 32'(m_aovf));
    check({where, ":b_ovf"}, 32'(b_ovf), 32'(m_bovf));
    check({where, ":skew_err"}, 32'(skew_err), 32'(m_err));
  endtask

  task automatic step(input bit av, input logic [W-1:0] ad, input bit bv, input logic [W-1:0] bd,
                      input bit rdy, input bit clr);
    bit pop, fl, fa, fb, wa, wb, da, db, ns;
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; pair_ready = rdy; clr_err = clr;
    pop = qa.size() > 0 && qb.size() > 0 && rdy;
    fl  = in_skew && (age + 1 == TO);
    fa  = fl && qa.size() > 0;
    fb  = fl && qb.size() > 0;
    wa  = av && (qa.size() < D || pop) && !fa;
    wb  = bv && (qb.size() < D || pop) && !fb;
    da  = av && qa.size() == D && !pop && !fa;
    db  = bv && qb.size() == D && !pop && !fb;
    @(posedge clk);
    if (pop) begin void'(qa.pop_front()); void'(qb.pop_front()); end
    if (fa) qa.delete();
    if (fb) qb.delete();
    if (wa) qa.push_back(ad);
    if (wb) qb.push_back(bd);
    m_aovf = da || (m_aovf && !clr);
    m_bovf = db || (m_bovf && !clr);
    m_err  = fl;
    if (fl) begin
      in_skew = 0; age = 0;
    end else begin
      ns = (qa.size() > 0) != (qb.size() > 0);
      age = (ns && in_skew) ? age + 1 : 0;
      in_skew = ns;
    end
    #1 check_outs("step");
  endtask

  task automatic do_reset();
    rst = 0;
    qa.delete(); qb.delete();
    m_aovf = 0; m_bovf = 0; m_err = 0; in_skew = 0; age = 0;
    #1 check_outs("rst_now");
    a_valid = 1; b_valid = 1; a_data = 16'hDEAD; b_data = 16'hBEEF; pair_ready = 1;
    repeat (2) @(posedge clk);
    #1 check_outs("rst_hold");
    a_valid = 0; b_valid = 0; pair_ready = 0;
    rst = 1;
  endtask

  initial begin
    #2 check_outs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1;
    // simultaneous pair, consumed at once
    step(1, 16'h1111, 1, 16'h2222, 1, 0);
    check("pair_a_1111", 32'(pair_a), 32'h1111);
    check("pair_b_2222", 32'(pair_b), 32'h2222);
    step(0, 0, 0, 0, 1, 0);
    check("pair_gone", 32'(pair_valid), 0);
    // A overflow, clear, then drain to show 0xA4 never stored
    for (int i = 0; i < 5; i++) step(1, 16'(16'hA0 + i), 0, 0, 0, 0);
    check("a_ovf_set", 32'(a_ovf), 1);
    step(0, 0, 0, 0, 0, 1);
    check("a_ovf_clr", 32'(a_ovf), 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 16'(16'hB0 + i), 1, 0);
      check("drain_a", 32'(pair_a), 32'(16'hA0 + i));
    end
    step(0, 0, 0, 0, 1, 0);
    check("a4_dropped", 32'(pair_valid), 0);
    // skew timeout
    do_reset();
    step(1, 16'h0055, 0, 0, 0, 0);
    for (int k = 1; k <= TO; k++) begin
      step(0, 0, 0, 0, 0, 0);
      check("skew_pulse", 32'(skew_err), 32'(k == TO));
    end
    step(0, 0, 1, 16'h0066, 0, 0);
    check("a_flushed", 32'(pair_valid), 0);
    check("err_one_cycle", 32'(skew_err), 0);
    // both full, pop and write together
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 16'(16'hC0 + i), 1, 16'(16'hD0 + i), 0, 0);
    step(1, 16'h00C4, 1, 16'h00D4, 1, 0);
    check("full_swap_aovf", 32'(a_ovf), 0);
    check("full_swap_bovf", 32'(b_ovf), 0);
    check("full_swap_head", 32'(pair_a), 32'h00C1);
    step(1, 16'h00C5, 1, 16'h00D5, 0, 0);
    check("still_full", 32'(a_ovf & b_ovf), 1);
    // reset mid-transfer, then normal delivery
    do_reset();
    step(1, 16'h0001, 1, 16'h0002, 0, 0);
    check("pre_rst_pv", 32'(pair_valid), 1);
    do_reset();
    check("post_rst_pv", 32'(pair_valid), 0);
    step(1, 16'h0007, 1, 16'h0008, 1, 0);
    check("after_rst_a", 32'(pair_a), 32'h0007);
    check("after_rst_b", 32'(pair_b), 32'h0008);
    // randomized phases with varying channel rates
    for (int p = 0; p < 16; p++) begin
      int pa, pb, pr;
      pa = $urandom_range(0, 100);
      pb = (p % 4 == 3) ? 0 : $urandom_range(0, 100);
      pr = $urandom_range(0, 100);
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 499) == 0) do_reset();
        step($urandom_range(0, 99) < pa, 16'($urandom), $urandom_range(0, 99) < pb, 16'($urandom),
             $urandom_range(0, 99) < pr, $urandom_range(0, 31) == 0);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_pair_aligner.md
BUS_PAIR_ALIGNER -- requirements
Module: bus_pair_aligner

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, the width of one bus word.
REQ-002 The block SHALL have parameter DEPTH, default 4 (power of two, >=2), the entries per channel FIFO.
REQ-003 The block SHALL have parameter TIMEOUT, default 255 (1..65535), the maximum cycles one channel may lead the other.
REQ-004 The block SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port a_valid  input  1  channel A word strobe.
REQ-007 The block SHALL have port a_data  input  DATA_W  channel A word.
REQ-008 The block SHALL have port b_valid  input  1  channel B word strobe.
REQ-009 The block SHALL have port b_data  input  DATA_W  channel B word.
REQ-010 The block SHALL have port pair_valid  output  1  aligned A/B pair available to the comparator.
REQ-011 The block SHALL have port pair_a  output  DATA_W  channel A word of the current pair.
REQ-012 The block SHALL have port pair_b  output  DATA_W  channel B word of the current pair.
REQ-013 The block SHALL have port pair_ready  input  1  comparator accepts the pair.
REQ-014 The block SHALL have port clr_err  input  1  synchronous clear of sticky flags.
REQ-015 The block SHALL have port a_ovf  output  1  sticky: a channel A word was dropped.
REQ-016 The block SHALL have port b_ovf  output  1  sticky: a channel B word was dropped.
REQ-017 The block SHALL have port skew_err  output  1  one-cycle pulse: skew timeout flush.

Function
REQ-018 Each channel SHALL own an independent DEPTH-entry FIFO with binary read/write pointers that wrap modulo DEPTH and an occupancy counter of width log2(DEPTH)+1.
REQ-019 A word SHALL be written when x_valid=1 and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-020 A word presented to a full FIFO with no pop in that cycle SHALL be dropped and set x_ovf on the next edge.
REQ-021 pair_valid SHALL be 1 exactly when both FIFOs are non-empty; pair_a/pair_b SHALL show the FIFO heads, and are 0 whenever pair_valid=0.
REQ-022 A word written at edge N SHALL be visible at the outputs after edge N (one-cycle latency) if the other channel is already non-empty.
REQ-023 Both FIFOs SHALL pop together only when pair_valid=1 and pair_ready=1; pair_a/pair_b SHALL stay stable while pair_valid=1 and pair_ready=0.
REQ-024 The skew FSM SHALL have states ALIGNED (both FIFOs empty or both non-empty) and SKEW (exactly one FIFO non-empty), evaluated on post-edge occupancy.
REQ-025 In SKEW, a 16-bit counter SHALL increment each cycle; entering ALIGNED SHALL clear it to 0.
REQ-026 When the counter reaches TIMEOUT, the block SHALL flush the non-empty FIFO (pointers equalised, count 0), pulse skew_err for one cycle, clear the counter, and go to ALIGNED.
REQ-027 On a flush cycle, a write to the flushed channel SHALL be discarded; a write to the empty channel SHALL be accepted.
REQ-028 clr_err=1 SHALL clear a_ovf and b_ovf on the next edge; a drop in that same cycle SHALL win, and the flag SHALL remain 1.
REQ-029 Simultaneous writes to both channels and a pop in one cycle SHALL all take effect, with no loss.

Reset
REQ-030 rst=0 SHALL immediately clear both FIFOs, the counter and the sticky flags, and force the FSM to ALIGNED, pair_valid=0, pair_a=pair_b=0, a_ovf=b_ovf=0 and skew_err=0, including mid-transfer.
REQ-031 FIFO storage contents SHALL need no reset; input strobes SHALL be ignored while rst=0.
REQ-032 After rst rises, the first write SHALL be accepted on the first rising edge.

Verification
REQ-033 Writes A=0x1111 and B=0x2222 in the same cycle, with pair_ready=1 -> pair_valid=1 for one cycle with pair_a=0x1111 and pair_b=0x2222, then 0.
REQ-034 Five A writes (0xA0..0xA4), no B, and pair_ready=0 -> 0xA4 is dropped and a_ovf=1; clr_err -> a_ovf=0.
REQ-035 One A write, no B, and TIMEOUT=8 -> skew_err pulses 8 cycles after the write, the A FIFO is empty, and pair_valid stays 0.
REQ-036 A full and B full, pair_ready=1, with new A and B writes in the same cycle -> no ovf, and occupancy stays 4/4.
REQ-037 Assert rst while pair_valid=1 and pair_ready=0 -> all outputs are 0 immediately; after release, a new A/B pair is delivered normally.
